// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment patterns are active low, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

  typedef enum logic {S_BLANK = 1'b0, S_ON = 1'b1} state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b000_0001;
  localparam logic [6:0] SEG_1 = 7'b100_1111;
  localparam logic [6:0] SEG_2 = 7'b001_0010;
  localparam logic [6:0] SEG_3 = 7'b000_0110;
  localparam logic [6:0] SEG_4 = 7'b100_1100;
  localparam logic [6:0] SEG_5 = 7'b010_0100;
  localparam logic [6:0] SEG_6 = 7'b010_0000;
  localparam logic [6:0] SEG_7 = 7'b000_1111;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b000_0100;
  localparam logic [6:0] SEG_A = 7'b000_1000;
  localparam logic [6:0] SEG_B = 7'b110_0000;
  localparam logic [6:0] SEG_C = 7'b011_0001;
  localparam logic [6:0] SEG_D = 7'b100_0010;
  localparam logic [6:0] SEG_E = 7'b011_0000;
  localparam logic [6:0] SEG_F = 7'b011_1000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Per-digit dark vector: forced blanking plus leading-zero suppression.
// Digit 0 is never suppressed so an all-zero value still shows a single '0'.
module seg7_lz_mask
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8
) (
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_blank_mask,
  input  logic                  i_lz_en,
  output logic [N_DIGITS-1:0]   o_dark
);

  // w_zero_above[i] = every digit j >= i is zero
  logic [N_DIGITS:0] w_zero_above;

  always_comb begin
    w_zero_above           = '0;
    w_zero_above[N_DIGITS] = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_zero_above[i] = w_zero_above[i+1] & (i_value[4*i +: 4] == 4'h0);
    end
    o_dark = i_blank_mask;
    for (int i = 1; i < N_DIGITS; i++) begin
      o_dark[i] = i_blank_mask[i] | (i_lz_en & w_zero_above[i]);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode driver: shadow registers, blank/on
// slot FSM, and registered SEG/DP/AN outputs sampled at each slot entry.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int ON_CYC    = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  lz_en,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [N_DIGITS-1:0]   AN,
  output logic [3:0]            seg_debug,
  output logic [2:0]            an_debug
);

  localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                w_enter_on, w_leave_on;

  logic [4*N_DIGITS-1:0] r_value;
  logic [N_DIGITS-1:0]   r_blank_mask, r_dp_mask;
  logic                  r_lz_en;
  logic [N_DIGITS-1:0]   w_dark;

  logic [6:0]          r_seg, w_seg_nxt;
  logic                r_dp_out, w_dp_nxt;
  logic [N_DIGITS-1:0] r_an, w_an_nxt, w_an_sel;
  logic [3:0]          r_seg_dbg, w_seg_dbg_nxt, w_digit;

  seg7_lz_mask #(.N_DIGITS(N_DIGITS)) u_lz_mask (
    .i_value      (r_value),
    .i_blank_mask (r_blank_mask),
    .i_lz_en      (r_lz_en),
    .o_dark       (w_dark)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_enter_on  = 1'b0;
    w_leave_on  = 1'b0;
    case (r_state)
      S_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = '0;
          w_enter_on  = 1'b1;
        end
      end
      default: begin
        if (r_cnt == ON_LAST) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_leave_on  = 1'b1;
          w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
    endcase
  end

  // Digit data is captured only on slot entry and held for the whole slot
  always_comb begin
    w_digit       = r_value[{r_idx, 2'b00} +: 4];
    w_an_sel      = ~(N_DIGITS'(1) << r_idx);
    w_seg_nxt     = r_seg;
    w_dp_nxt      = r_dp_out;
    w_an_nxt      = r_an;
    w_seg_dbg_nxt = r_seg_dbg;
    if (w_enter_on) begin
      w_dp_nxt = ~r_dp_mask[r_idx];
      if (w_dark[r_idx]) begin
        w_seg_nxt     = SEG_OFF;
        w_seg_dbg_nxt = 4'hF;
        w_an_nxt      = r_dp_mask[r_idx] ? w_an_sel : '1;
      end else begin
        w_seg_nxt     = hex_to_seg(w_digit);
        w_seg_dbg_nxt = w_digit;
        w_an_nxt      = w_an_sel;
      end
    end else if (w_leave_on) begin
      w_seg_nxt     = SEG_OFF;
      w_dp_nxt      = 1'b1;
      w_an_nxt      = '1;
      w_seg_dbg_nxt = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_value      <= '0;
      r_blank_mask <= '0;
      r_dp_mask    <= '0;
      r_lz_en      <= 1'b0;
      r_seg        <= SEG_OFF;
      r_dp_out     <= 1'b1;
      r_an         <= '1;
      r_seg_dbg    <= 4'hF;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_seg     <= w_seg_nxt;
      r_dp_out  <= w_dp_nxt;
      r_an      <= w_an_nxt;
      r_seg_dbg <= w_seg_dbg_nxt;
      if (load) begin
        r_value      <= value;
        r_blank_mask <= blank_mask;
        r_dp_mask    <= dp_mask;
        r_lz_en      <= lz_en;
      end
    end
  end

  assign SEG       = r_seg;
  assign DP        = r_dp_out;
  assign AN        = r_an;
  assign seg_debug = r_seg_dbg;
  assign an_debug  = 3'(r_idx);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 4 on-cycles, 2 blank-cycles): directed
// vector table, hand-written corner sequences and random traffic vs a slot model.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int ON = 4;
  localparam int BL = 2;
  localparam int SLOT = ON + BL;
  localparam int PERIOD = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    blank_mask = '0;
  logic [3:0]    dp_mask = '0;
  logic          lz_en = 1'b0;
  logic [6:0]    SEG;
  logic          DP;
  logic [3:0]    AN;
  logic [3:0]    seg_debug;
  logic [2:0]    an_debug;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: edges since last reset, shadows, slot snapshot
  int          m_k = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_blank = '0, m_dp = '0;
  logic        m_lz = 1'b0;
  logic [15:0] s_val = '0;
  logic [3:0]  s_blank = '0, s_dp = '0;
  logic        s_lz = 1'b0;

  logic [6:0] seg_tbl [16];

  typedef struct {
    logic [15:0] val;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic        lz;
    int          dig;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_dp;
    logic [3:0]  e_dbg;
  } vec_t;

  vec_t vecs [20];

  seg7_scan_driver #(.N_DIGITS(ND), .ON_CYC(ON), .BLANK_CYC(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .lz_en      (lz_en),
    .SEG        (SEG),
    .DP         (DP),
    .AN         (AN),
    .seg_debug  (seg_debug),
    .an_debug   (an_debug)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t k=%0d)", name, act, exp, $time, m_k);
    end
  endtask

  // expected {AN,SEG,DP,seg_debug,an_debug} from position within the scan period
  function automatic logic [18:0] model_out();
    int p, slot, q;
    logic [3:0] d, sel;
    logic dark;
    p    = m_k % PERIOD;
    slot = p / SLOT;
    q    = p % SLOT;
    sel  = ~(4'b0001 << slot);
    if (q < BL) return {4'hF, 7'h7F, 1'b1, 4'hF, 3'(slot)};
    d    = 4'((s_val >> (4 * slot)) & 16'hF);
    dark = s_blank[slot] || (s_lz && slot > 0 && (s_val >> (4 * slot)) == 16'h0);
    if (dark)
      return {(s_dp[slot] ? sel : 4'hF), 7'h7F, ~s_dp[slot], 4'hF, 3'(slot)};
    return {sel, seg_tbl[d], ~s_dp[slot], d, 3'(slot)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_k = 0;
      m_val = '0; m_blank = '0; m_dp = '0; m_lz = 1'b0;
    end else begin
      m_k++;
      if (m_k % SLOT == BL) begin
        s_val = m_val; s_blank = m_blank; s_dp = m_dp; s_lz = m_lz;
      end
      if (load) begin
        m_val = value; m_blank = blank_mask; m_dp = dp_mask; m_lz = lz_en;
      end
    end
    #1;
    chk("model", {AN, SEG, DP, seg_debug, an_debug}, model_out());
  endtask

  task automatic run_to(input int k);
    for (int n = 0; n < 200 && m_k < k; n++) tick();
  endtask

  task automatic reset_and_load(input logic [15:0] v, input logic [3:0] b,
                                input logic [3:0] d, input logic l);
    rst = 1'b1; load = 1'b0;
    tick();
    rst = 1'b0; load = 1'b1; value = v; blank_mask = b; dp_mask = d; lz_en = l;
    tick();
    load = 1'b0;
  endtask

  initial begin
    seg_tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    vecs[0]  = '{16'h9863, 4'h0, 4'h0, 1'b0, 0, 7'h06, 4'b1110, 1'b1, 4'h3};
    vecs[1]  = '{16'h9863, 4'h0, 4'h0, 1'b0, 1, 7'h20, 4'b1101, 1'b1, 4'h6};
    vecs[2]  = '{16'h9863, 4'h0, 4'h0, 1'b0, 2, 7'h00, 4'b1011, 1'b1, 4'h8};
    vecs[3]  = '{16'h9863, 4'h0, 4'h0, 1'b0, 3, 7'h04, 4'b0111, 1'b1, 4'h9};
    vecs[4]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 3, 7'h7F, 4'b1111, 1'b1, 4'hF};
    vecs[5]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 2, 7'h7F, 4'b1111, 1'b1, 4'hF};
    vecs[6]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 1, 7'h24, 4'b1101, 1'b1, 4'h5};
    vecs[7]  = '{16'h0050, 4'h0, 4'h0, 1'b1, 0, 7'h01, 4'b1110, 1'b1, 4'h0};
    vecs[8]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 0, 7'h01, 4'b1110, 1'b1, 4'h0};
    vecs[9]  = '{16'h0000, 4'h0, 4'h0, 1'b1, 1, 7'h7F, 4'b1111, 1'b1, 4'hF};
    vecs[10] = '{16'hABCD, 4'b0010, 4'b0100, 1'b0, 1, 7'h7F, 4'b1111, 1'b1, 4'hF};
    vecs[11] = '{16'hABCD, 4'b0010, 4'b0100, 1'b0, 2, 7'h60, 4'b1011, 1'b0, 4'hB};
    vecs[12] = '{16'hABCD, 4'b0010, 4'b0100, 1'b0, 0, 7'h42, 4'b1110, 1'b1, 4'hD};
    vecs[13] = '{16'hABCD, 4'b0010, 4'b0100, 1'b0, 3, 7'h08, 4'b0111, 1'b1, 4'hA};
    vecs[14] = '{16'h0000, 4'h0, 4'b1000, 1'b1, 3, 7'h7F, 4'b0111, 1'b0, 4'hF};
    vecs[15] = '{16'h0050, 4'h0, 4'h0, 1'b0, 3, 7'h01, 4'b0111, 1'b1, 4'h0};
    vecs[16] = '{16'hCE7F, 4'h0, 4'h0, 1'b0, 0, 7'h38, 4'b1110, 1'b1, 4'hF};
    vecs[17] = '{16'hCE7F, 4'h0, 4'h0, 1'b0, 1, 7'h0F, 4'b1101, 1'b1, 4'h7};
    vecs[18] = '{16'hCE7F, 4'h0, 4'h0, 1'b0, 2, 7'h30, 4'b1011, 1'b1, 4'hE};
    vecs[19] = '{16'h4210, 4'h0, 4'h0, 1'b1, 3, 7'h4C, 4'b0111, 1'b1, 4'h4};

    // reset held for three edges, then the first slot entry two edges later
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_out", {AN, SEG, DP, seg_debug, an_debug}, {4'hF, 7'h7F, 1'b1, 4'hF, 3'd0});
    end
    rst = 1'b0;
    tick();
    chk("post_reset_blank_an", AN, 4'b1111);
    tick();
    chk("first_on_an", AN, 4'b1110);
    chk("first_on_seg", SEG, 7'h01);

    // directed vector table
    for (int v = 0; v < 20; v++) begin
      reset_and_load(vecs[v].val, vecs[v].blank, vecs[v].dp, vecs[v].lz);
      run_to(SLOT * vecs[v].dig + BL + 1);
      chk($sformatf("vec%0d_seg", v), SEG, vecs[v].e_seg);
      chk($sformatf("vec%0d_an", v), AN, vecs[v].e_an);
      chk($sformatf("vec%0d_dp", v), DP, vecs[v].e_dp);
      chk($sformatf("vec%0d_dbg", v), seg_debug, vecs[v].e_dbg);
      chk($sformatf("vec%0d_idx", v), an_debug, 3'(vecs[v].dig));
    end

    // full scan wrap and mid-slot load
    reset_and_load(16'h9863, 4'h0, 4'h0, 1'b0);
    run_to(15);
    chk("d2_on_seg", SEG, 7'h00);
    load = 1'b1; value = 16'h1111;
    tick();
    load = 1'b0;
    chk("midload_hold_seg", SEG, 7'h00);
    tick();
    chk("midload_hold_dbg", seg_debug, 4'h8);
    run_to(20);
    chk("midload_next_seg", SEG, 7'h4F);
    chk("midload_next_an", AN, 4'b0111);
    // reset during digit 3 on-slot
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_an", AN, 4'b1111);
    chk("rst_mid_idx", an_debug, 3'd0);
    tick();
    chk("rst_mid_blank2", AN, 4'b1111);
    tick();
    chk("rst_mid_d0_an", AN, 4'b1110);
    chk("rst_mid_d0_seg", SEG, 7'h01);

    // scan wrap after a full period
    reset_and_load(16'h9863, 4'h0, 4'h0, 1'b0);
    run_to(PERIOD);
    chk("wrap_blank_an", AN, 4'b1111);
    chk("wrap_idx", an_debug, 3'd0);
    run_to(PERIOD + BL);
    chk("wrap_d0_an", AN, 4'b1110);
    chk("wrap_d0_seg", SEG, 7'h06);

    // load together with reset: reset wins
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_mask = 4'hF; blank_mask = 4'h0; lz_en = 1'b0;
    tick();
    rst = 1'b0; load = 1'b0;
    run_to(BL);
    chk("ldrst_seg", SEG, 7'h01);
    chk("ldrst_dp", DP, 1'b1);
    chk("ldrst_an", AN, 4'b1110);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      load       = ($urandom_range(0, 7) == 0);
      value      = 16'($urandom);
      if ($urandom_range(0, 2) == 0) value = value & 16'h00FF;
      if ($urandom_range(0, 3) == 0) value = 16'h0000;
      blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      dp_mask    = 4'($urandom);
      lz_en      = 1'($urandom);
      rst        = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
